// File: rtl/apb_req_master_pkg.sv
// Shared types and constants for the core-to-APB request bridge.
package apb_req_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Peripheral window of the SoC memory map.
  localparam logic [31:0] WIN_START_DEF = 32'h1A10_0000;
  localparam logic [31:0] WIN_END_DEF   = 32'h1A11_7FFF;

  localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait counter; tc_o flags the cycle in which the count would
// reach TIMEOUT_CYCLES. TIMEOUT_CYCLES == 0 removes the counter entirely.
module apb_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign tc_o = 1'b0;
    end else begin : g_on
      localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
      localparam logic [CW-1:0] TC_MAX  = CW'(TIMEOUT_CYCLES);
      localparam logic [CW-1:0] TC_LAST = CW'(TIMEOUT_CYCLES - 1);

      logic [CW-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
          cnt_d = '0;
        else if (en_i && (cnt_q != TC_MAX))  // saturate, never wrap
          cnt_d = cnt_q + 1'b1;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
      end

      assign tc_o = en_i && (cnt_q == TC_LAST);
    end
  endgenerate

endmodule

// File: rtl/apb_req_master.sv
// Core request channel (req/gnt/rvalid) to APB3 master bridge: one transfer
// per request, window check, and ACCESS-phase timeout abort.
module apb_req_master
  import apb_req_master_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter logic [APB_ADDR_WIDTH-1:0] WIN_START = WIN_START_DEF,
  parameter logic [APB_ADDR_WIDTH-1:0] WIN_END   = WIN_END_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic                      we_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr,
  output logic [APB_DATA_WIDTH-1:0] pwdata,
  output logic                      pwrite,
  output logic                      psel,
  output logic                      penable,
  input  logic [APB_DATA_WIDTH-1:0] prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  localparam logic [APB_DATA_WIDTH-1:0] ERR_DATA = APB_DATA_WIDTH'(ERR_RDATA);

  state_e                    state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      rvalid_q, rvalid_d;
  logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;

  logic accept, in_win, to_clr, to_en, to_tc;

  assign gnt_o  = (state_q == IDLE);
  assign accept = req_i && gnt_o;
  assign in_win = (addr_i >= WIN_START) && (addr_i <= WIN_END);
  assign to_clr = accept;
  assign to_en  = (state_q == ACCESS) && !pready;

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clr_i (to_clr),
    .en_i  (to_en),
    .tc_o  (to_tc)
  );

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_win) begin
            paddr_d  = addr_i;
            pwrite_d = we_i;
            pwdata_d = wdata_i;
            state_d  = SETUP;
          end else begin
            rdata_d = ERR_DATA;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // pready in the terminal-count cycle still completes normally
        if (pready) begin
          rdata_d = pwrite_q ? ERR_DATA : prdata;
          err_d   = pslverr;
          state_d = RESP;
        end else if (to_tc) begin
          rdata_d = ERR_DATA;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    psel_d    = (state_d == SETUP) || (state_d == ACCESS);
    penable_d = (state_d == ACCESS);
    rvalid_d  = (state_d == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign paddr    = paddr_q;
  assign pwdata   = pwdata_q;
  assign pwrite   = pwrite_q;
  assign psel     = psel_q;
  assign penable  = penable_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_apb_req_master.sv
// Directed bench for apb_req_master with TIMEOUT_CYCLES=4; slave responses
// are driven cycle by cycle from each scenario task.
module tb_apb_req_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i, we_i;
  logic        gnt_o, rvalid_o, err_o;
  logic [31:0] addr_i, wdata_i, rdata_o;
  logic [31:0] paddr, pwdata, prdata;
  logic        pwrite, psel, penable, pready, pslverr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  apb_req_master #(
    .APB_ADDR_WIDTH (32),
    .APB_DATA_WIDTH (32),
    .TIMEOUT_CYCLES (4),
    .WIN_START      (32'h1A10_0000),
    .WIN_END        (32'h1A11_7FFF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_i),
    .gnt_o    (gnt_o),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .rvalid_o (rvalid_o),
    .rdata_o  (rdata_o),
    .err_o    (err_o),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .pwrite   (pwrite),
    .psel     (psel),
    .penable  (penable),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr)
  );

  // advance to just after the next active edge
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_i = 0; we_i = 0; addr_i = '0; wdata_i = '0;
    prdata = '0; pready = 0; pslverr = 0;
    #1 rst = 1'b1;
    #2;
    checks++;
    if ({gnt_o, psel, penable, pwrite, rvalid_o, err_o} !== 6'b100000) begin
      errors++; $display("FAIL reset_ctrl got gnt/psel/pen/pwr/rv/err=%b exp 100000",
                         {gnt_o, psel, penable, pwrite, rvalid_o, err_o});
    end
    checks++;
    if ({paddr, pwdata, rdata_o} !== 96'h0) begin
      errors++; $display("FAIL reset_data got paddr=%h pwdata=%h rdata=%h exp 0", paddr, pwdata, rdata_o);
    end
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_read();
    req_i = 1; we_i = 0; addr_i = 32'h1A10_1000; wdata_i = 32'hFFFF_FFFF;
    @(negedge clk); checks++;
    if (gnt_o !== 1'b1) begin errors++; $display("FAIL read_gnt got %b exp 1", gnt_o); end
    cyc(); req_i = 0; addr_i = '0;
    @(negedge clk); checks++;
    if ({psel, penable, pwrite, paddr} !== {3'b100, 32'h1A10_1000}) begin
      errors++; $display("FAIL read_setup got sel/en/wr=%b%b%b paddr=%h exp 100 1a101000", psel, penable, pwrite, paddr);
    end
    cyc(); pready = 1; prdata = 32'h1234_5678;
    @(negedge clk); checks++;
    if ({psel, penable, rvalid_o} !== 3'b110) begin
      errors++; $display("FAIL read_access got sel/en/rv=%b exp 110", {psel, penable, rvalid_o});
    end
    cyc(); pready = 0; prdata = '0;
    @(negedge clk); checks++;
    if ({rvalid_o, err_o, psel, rdata_o} !== {3'b100, 32'h1234_5678}) begin
      errors++; $display("FAIL read_resp got rv/err/sel=%b rdata=%h exp 100 12345678", {rvalid_o, err_o, psel}, rdata_o);
    end
    cyc();
    @(negedge clk); checks++;
    if ({rvalid_o, gnt_o} !== 2'b01) begin
      errors++; $display("FAIL read_idle got rv/gnt=%b exp 01", {rvalid_o, gnt_o});
    end
    cyc();
  endtask

  task automatic test_write_wait();
    req_i = 1; we_i = 1; addr_i = 32'h1A10_3004; wdata_i = 32'hCAFE_F00D;
    cyc(); req_i = 0; we_i = 0; addr_i = 32'h0BAD_0000; wdata_i = 32'h0;
    prdata = 32'h7777_7777;
    // SETUP + 3 wait states + final ACCESS with pready
    for (int k = 0; k < 5; k++) begin
      pready = (k == 4);
      @(negedge clk); checks++;
      if ({psel, penable, pwrite, rvalid_o, paddr, pwdata} !==
          {1'b1, (k != 0), 1'b1, 1'b0, 32'h1A10_3004, 32'hCAFE_F00D}) begin
        errors++; $display("FAIL write_bus[%0d] got sel/en/wr/rv=%b paddr=%h pwdata=%h exp 1%0b10 1a103004 cafef00d",
                           k, {psel, penable, pwrite, rvalid_o}, paddr, pwdata, (k != 0));
      end
      cyc();
    end
    pready = 0;
    @(negedge clk); checks++;
    if ({rvalid_o, err_o, psel, rdata_o} !== {3'b100, 32'h0}) begin
      errors++; $display("FAIL write_resp got rv/err/sel=%b rdata=%h exp 100 0", {rvalid_o, err_o, psel}, rdata_o);
    end
    cyc();
  endtask

  task automatic test_slverr();
    req_i = 1; we_i = 0; addr_i = 32'h1A10_2000;
    cyc(); req_i = 0;
    cyc(); pready = 1; pslverr = 1; prdata = 32'hDEAD_BEEF;
    cyc(); pready = 0; pslverr = 0; prdata = '0;
    @(negedge clk); checks++;
    if ({rvalid_o, err_o, rdata_o} !== {2'b11, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL slverr_resp got rv/err=%b rdata=%h exp 11 deadbeef", {rvalid_o, err_o}, rdata_o);
    end
    cyc();
  endtask

  task automatic test_window();
    logic [31:0] wa [5];
    bit          ok [5];
    wa[0] = 32'h2000_0000; ok[0] = 0;
    wa[1] = 32'h1A11_7FFF; ok[1] = 1;
    wa[2] = 32'h1A11_8000; ok[2] = 0;
    wa[3] = 32'h1A0F_FFFC; ok[3] = 0;
    wa[4] = 32'h1A10_0000; ok[4] = 1;
    for (int i = 0; i < 5; i++) begin
      req_i = 1; we_i = 0; addr_i = wa[i];
      cyc(); req_i = 0;
      if (!ok[i]) begin
        @(negedge clk); checks++;
        if ({rvalid_o, err_o, psel, rdata_o} !== {3'b110, 32'h0}) begin
          errors++; $display("FAIL win_rej[%h] got rv/err/sel=%b rdata=%h exp 110 0", wa[i], {rvalid_o, err_o, psel}, rdata_o);
        end
        cyc();
        @(negedge clk); checks++;
        if ({psel, rvalid_o, gnt_o} !== 3'b001) begin
          errors++; $display("FAIL win_rej_idle[%h] got sel/rv/gnt=%b exp 001", wa[i], {psel, rvalid_o, gnt_o});
        end
      end else begin
        @(negedge clk); checks++;
        if ({psel, paddr} !== {1'b1, wa[i]}) begin
          errors++; $display("FAIL win_acc[%h] got sel=%b paddr=%h exp 1", wa[i], psel, paddr);
        end
        cyc(); pready = 1; prdata = wa[i] ^ 32'hFFFF_0000;
        cyc(); pready = 0;
        @(negedge clk); checks++;
        if ({rvalid_o, err_o, rdata_o} !== {2'b10, wa[i] ^ 32'hFFFF_0000}) begin
          errors++; $display("FAIL win_acc_resp[%h] got rv/err=%b rdata=%h exp 10 %h",
                             wa[i], {rvalid_o, err_o}, rdata_o, wa[i] ^ 32'hFFFF_0000);
        end
      end
      cyc();
    end
  endtask

  task automatic test_timeout();
    for (int run = 0; run < 2; run++) begin
      req_i = 1; we_i = 0; addr_i = 32'h1A10_5000; prdata = 32'h0000_55AA;
      cyc(); req_i = 0;
      cyc();
      for (int k = 0; k < 4; k++) begin
        pready = (run == 1) && (k == 3);
        @(negedge clk); checks++;
        if ({psel, penable, rvalid_o} !== 3'b110) begin
          errors++; $display("FAIL tmo_access[%0d/%0d] got sel/en/rv=%b exp 110", run, k, {psel, penable, rvalid_o});
        end
        cyc();
      end
      pready = 0;
      @(negedge clk); checks++;
      if (run == 0) begin
        if ({rvalid_o, err_o, psel, penable, rdata_o} !== {4'b1100, 32'h0}) begin
          errors++; $display("FAIL tmo_abort got rv/err/sel/en=%b rdata=%h exp 1100 0", {rvalid_o, err_o, psel, penable}, rdata_o);
        end
      end else begin
        if ({rvalid_o, err_o, psel, rdata_o} !== {3'b100, 32'h0000_55AA}) begin
          errors++; $display("FAIL tmo_late_ready got rv/err/sel=%b rdata=%h exp 100 000055aa", {rvalid_o, err_o, psel}, rdata_o);
        end
      end
      cyc();
    end
  endtask

  task automatic test_reset_mid();
    req_i = 1; we_i = 0; addr_i = 32'h1A10_4000;
    cyc(); req_i = 0;
    cyc(); pready = 0;
    @(negedge clk); checks++;
    if ({psel, penable} !== 2'b11) begin
      errors++; $display("FAIL rstmid_pre got sel/en=%b exp 11", {psel, penable});
    end
    #2 rst = 1'b1;
    #1; checks++;
    if ({psel, penable, rvalid_o} !== 3'b000) begin
      errors++; $display("FAIL rstmid_async got sel/en/rv=%b exp 000", {psel, penable, rvalid_o});
    end
    cyc(); rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); checks++;
      if ({rvalid_o, psel, gnt_o} !== 3'b001) begin
        errors++; $display("FAIL rstmid_post[%0d] got rv/sel/gnt=%b exp 001", k, {rvalid_o, psel, gnt_o});
      end
      cyc();
    end
  endtask

  task automatic test_back_to_back();
    req_i = 1; we_i = 0; addr_i = 32'h1A10_0100; pready = 1; prdata = 32'h0B0B_0001;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); checks++;
      if ({gnt_o, rvalid_o} !== {(k % 4) == 0, (k % 4) == 3}) begin
        errors++; $display("FAIL b2b[%0d] got gnt/rv=%b exp %b%b", k, {gnt_o, rvalid_o}, (k % 4) == 0, (k % 4) == 3);
      end
      if ((k % 4) == 3) begin
        checks++;
        if ({err_o, rdata_o} !== {1'b0, 32'h0B0B_0001}) begin
          errors++; $display("FAIL b2b_data[%0d] got err=%b rdata=%h exp 0 0b0b0001", k, err_o, rdata_o);
        end
      end
      cyc();
    end
    req_i = 0; pready = 0;
    cyc();
  endtask

  initial begin
    test_reset();
    cyc();
    test_read();
    test_write_wait();
    test_slverr();
    test_window();
    test_timeout();
    test_reset_mid();
    test_read();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
